key_reader: RTL and testbench

Debounced pushbutton reader for the board's active-low KEY inputs, the input-side counterpart to the LED drivers. It synchronizes one raw key line and filters bounce with a cycle-counted stability window. It then produces a clean pressed level, single-cycle press/release/long-press pulses, and a wrapping press counter mirrored onto the green LEDs. Downstream logic in the same CLOCK_50 domain uses these outputs instead of raw KEY pins.

---
 rtl/key_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_key_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_reader.sv
// -----------------------------------------------------------------------------
// key_reader
//
// Debounced reader for one active-low pushbutton line. The raw key passes
// through a two-flop synchronizer. A four-state FSM then accepts a level change
// only after DB_CYC consecutive agreeing samples. The block produces a clean
// pressed level, single-cycle press/release/long-press pulses, and a wrapping
// 8-bit press counter that is mirrored onto the green LEDs.
//
// Parameters
//   CLK_HZ       clock frequency in Hz
//   DEBOUNCE_MS  stability window in ms; DB_CYC = (CLK_HZ/1000)*DEBOUNCE_MS, must be >= 2
//   LONG_MS      long-press threshold in ms; LONG_CYC = (CLK_HZ/1000)*LONG_MS, must be >= 1
//
// Ports
//   CLOCK_50       in   system clock, rising edge
//   RESET          in   synchronous active-high reset, highest priority
//   KEY_N          in   raw asynchronous key, 0 = pressed
//   PRESSED        out  debounced level, 1 = pressed
//   PRESS_PULSE    out  one-cycle pulse on each accepted press
//   RELEASE_PULSE  out  one-cycle pulse on each accepted release
//   LONG_PULSE     out  one-cycle pulse once a press has lasted LONG_CYC cycles
//   LONG_HELD      out  set with LONG_PULSE, cleared with RELEASE_PULSE
//   PRESS_COUNT    out  accepted presses modulo 256
//   LEDG           out  copy of PRESS_COUNT, active-high
//
// Every output is taken directly from a flop. There is no combinational path
// from KEY_N to any output.
// -----------------------------------------------------------------------------
module key_reader #(
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_N,
    output logic       PRESSED,
    output logic       PRESS_PULSE,
    output logic       RELEASE_PULSE,
    output logic       LONG_PULSE,
    output logic       LONG_HELD,
    output logic [7:0] PRESS_COUNT,
    output logic [7:0] LEDG
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int DB_CYC   = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int LONG_CYC = (CLK_HZ / 1000) * LONG_MS;

    // db_cnt only has to reach DB_CYC-1.
    // long_cnt has to hold LONG_CYC itself, because it saturates there.
    localparam int DB_W   = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
    localparam int LONG_W = (LONG_CYC > 1) ? $clog2(LONG_CYC + 1) : 1;

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYC);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,   // stable released
        ST_PRESS_WAIT = 2'd1,   // pressed candidate, counting agreeing samples
        ST_HELD       = 2'd2,   // stable pressed
        ST_REL_WAIT   = 2'd3    // release candidate, counting agreeing samples
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    state_t            state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              pressed_q, pressed_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              long_pulse_q, long_pulse_d;
    logic              long_held_q, long_held_d;
    logic [7:0]        press_count_q, press_count_d;

    // -------------------------------------------------------------------------
    // Synchronizer next-state
    // -------------------------------------------------------------------------
    always_comb begin
        s1_d = KEY_N;
        s2_d = s1_q;
    end

    // -------------------------------------------------------------------------
    // Debounce FSM and long-press tracking (next-state and outputs)
    // -------------------------------------------------------------------------
    logic release_now;   // a release is accepted on this edge
    logic in_press;      // a debounced press is in progress (HELD or REL_WAIT)

    always_comb begin
        state_d         = state_q;
        db_cnt_d        = db_cnt_q;
        long_cnt_d      = long_cnt_q;
        pressed_d       = pressed_q;
        long_held_d     = long_held_q;
        press_count_d   = press_count_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        release_now     = 1'b0;
        in_press        = (state_q == ST_HELD) || (state_q == ST_REL_WAIT);

        // Long-press timing runs through the whole press, including any
        // release bounce. A bounce does not restart it.
        if (in_press) begin
            if (long_cnt_q != LONG_SAT) begin
                long_cnt_d = long_cnt_q + LONG_ONE;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // The first low sample already counts toward the window.
                if (!s2_q) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end

            ST_PRESS_WAIT: begin
                if (s2_q) begin
                    state_d = ST_IDLE;          // bounce rejected, no pulse
                end else if (db_cnt_q == DB_LAST) begin
                    state_d       = ST_HELD;
                    press_pulse_d = 1'b1;
                    pressed_d     = 1'b1;
                    press_count_d = press_count_q + 8'd1;   // wraps 255 -> 0
                    long_cnt_d    = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            ST_HELD: begin
                if (s2_q) begin
                    state_d  = ST_REL_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end

            ST_REL_WAIT: begin
                if (!s2_q) begin
                    state_d = ST_HELD;          // release bounce, still pressed
                end else if (db_cnt_q == DB_LAST) begin
                    state_d         = ST_IDLE;
                    release_pulse_d = 1'b1;
                    pressed_d       = 1'b0;
                    long_held_d     = 1'b0;
                    release_now     = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // long_cnt becomes LONG_CYC on this edge. A release accepted on the
        // same edge takes precedence, so the press ends without a long pulse.
        if (in_press && (long_cnt_q == LONG_LAST) && !long_held_q && !release_now) begin
            long_pulse_d = 1'b1;
            long_held_d  = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            s1_q            <= 1'b1;
            s2_q            <= 1'b1;
            state_q         <= ST_IDLE;
            db_cnt_q        <= '0;
            long_cnt_q      <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            long_held_q     <= 1'b0;
            press_count_q   <= 8'd0;
        end else begin
            s1_q            <= s1_d;
            s2_q            <= s2_d;
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            long_cnt_q      <= long_cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            long_held_q     <= long_held_d;
            press_count_q   <= press_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign PRESSED       = pressed_q;
    assign PRESS_PULSE   = press_pulse_q;
    assign RELEASE_PULSE = release_pulse_q;
    assign LONG_PULSE    = long_pulse_q;
    assign LONG_HELD     = long_held_q;
    assign PRESS_COUNT   = press_count_q;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ledg
            assign LEDG[gi] = press_count_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_key_reader.sv
// -----------------------------------------------------------------------------
// tb_key_reader
//
// Drives key_reader with directed and randomized key patterns. Every cycle,
// the DUT outputs are compared against a reference model that works at the
// level of sample runs:
//   - The debounced level flips once the last DB_CYC synchronized samples all
//     show the opposite level.
//   - A long pulse is due exactly LONG_CYC edges after the accepted press,
//     unless the press has already ended.
// Latency and pulse-count checks for the listed scenarios are added on top.
// -----------------------------------------------------------------------------
module tb_key_reader;

    localparam int CLK_HZ      = 1000;
    localparam int DEBOUNCE_MS = 4;
    localparam int LONG_MS     = 10;
    localparam int DB_CYC      = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int LONG_CYC    = (CLK_HZ / 1000) * LONG_MS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_n = 1'b1;
    logic       pressed, press_pulse, release_pulse, long_pulse, long_held;
    logic [7:0] press_count, ledg;

    always #5 clk = ~clk;

    key_reader #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS)
    ) dut (
        .CLOCK_50      (clk),
        .RESET         (rst),
        .KEY_N         (key_n),
        .PRESSED       (pressed),
        .PRESS_PULSE   (press_pulse),
        .RELEASE_PULSE (release_pulse),
        .LONG_PULSE    (long_pulse),
        .LONG_HELD     (long_held),
        .PRESS_COUNT   (press_count),
        .LEDG          (ledg)
    );

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    int press_n, rel_n, long_n;
    int last_press_edge, last_rel_edge, last_long_edge;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    bit   m_s1 = 1'b1, m_s2 = 1'b1;
    bit   hist[$];                    // samples the debouncer has seen since reset
    bit   m_level = 1'b0;             // 1 = pressed
    int   m_count = 0;
    bit   m_long_held = 1'b0;
    bit   m_long_done = 1'b1;
    int   m_press_edge = 0;
    bit   e_press, e_rel, e_long;

    task automatic model_edge(input bit key, input bit r);
        bit sample, flip, prev;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        if (r) begin
            m_s1 = 1'b1;
            m_s2 = 1'b1;
            hist.delete();
            m_level     = 1'b0;
            m_count     = 0;
            m_long_held = 1'b0;
            m_long_done = 1'b1;
            return;
        end
        sample = m_s2;
        m_s2   = m_s1;
        m_s1   = key;
        hist.push_back(sample);
        if (hist.size() > DB_CYC) void'(hist.pop_front());
        // Active-low key: the raw sample that opposes level L has the value L.
        flip = (hist.size() == DB_CYC);
        foreach (hist[i]) if (hist[i] != m_level) flip = 1'b0;
        prev = m_level;
        if (flip) m_level = !m_level;
        e_press = !prev && m_level;
        e_rel   = prev && !m_level;
        if (e_press) begin
            m_count      = (m_count + 1) % 256;
            m_press_edge = edge_n;
            m_long_done  = 1'b0;
        end
        if (prev && !e_rel && !m_long_done && (edge_n - m_press_edge == LONG_CYC)) begin
            e_long      = 1'b1;
            m_long_held = 1'b1;
            m_long_done = 1'b1;
        end
        if (e_rel) begin
            m_long_held = 1'b0;
            m_long_done = 1'b1;
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick(input bit key, input bit r);
        @(negedge clk);
        key_n = key;
        rst   = r;
        edge_n++;
        model_edge(key, r);
        @(posedge clk);
        #1;
        check_eq("pressed",       32'(pressed),       32'(m_level));
        check_eq("press_pulse",   32'(press_pulse),   32'(e_press));
        check_eq("release_pulse", 32'(release_pulse), 32'(e_rel));
        check_eq("long_pulse",    32'(long_pulse),    32'(e_long));
        check_eq("long_held",     32'(long_held),     32'(m_long_held));
        check_eq("press_count",   32'(press_count),   32'(m_count));
        check_eq("ledg",          32'(ledg),          32'(m_count));
        if (press_pulse === 1'b1)   begin press_n++; last_press_edge = edge_n; end
        if (release_pulse === 1'b1) begin rel_n++;   last_rel_edge   = edge_n; end
        if (long_pulse === 1'b1)    begin long_n++;  last_long_edge  = edge_n; end
    endtask

    task automatic hold(input bit key, input int n);
        for (int i = 0; i < n; i++) tick(key, 1'b0);
    endtask

    task automatic start_scn();
        tick(1'b1, 1'b1);
        press_n = 0; rel_n = 0; long_n = 0;
        last_press_edge = -1; last_rel_edge = -1; last_long_edge = -1;
    endtask

    task automatic report(input string name);
        $display("scenario %s: presses=%0d releases=%0d longs=%0d count=%0d",
                 name, press_n, rel_n, long_n, press_count);
    endtask

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        int k, m, r;
        bit lvl;

        // Reset state
        start_scn();
        check_eq("reset_pressed", 32'(pressed), 32'd0);
        check_eq("reset_count",   32'(press_count), 32'd0);
        hold(1'b1, 4);
        report("reset");

        // Clean press: low for 8 samples, then high
        start_scn();
        hold(1'b1, 8);
        k = edge_n + 1;
        hold(1'b0, 8);
        m = edge_n + 1;
        hold(1'b1, 10);
        check_eq("clean_press_lat", 32'(last_press_edge - k), 32'(1 + DB_CYC));
        check_eq("clean_rel_lat",   32'(last_rel_edge - m),   32'(1 + DB_CYC));
        check_eq("clean_count",     32'(press_count), 32'd1);
        check_eq("clean_presses",   32'(press_n), 32'd1);
        report("clean_press");

        // Bounce rejection: 3 low, 1 high, 2 low, then high
        start_scn();
        hold(1'b1, 3);
        hold(1'b0, 3);
        hold(1'b1, 1);
        hold(1'b0, 2);
        hold(1'b1, 10);
        check_eq("bounce_presses", 32'(press_n), 32'd0);
        check_eq("bounce_count",   32'(press_count), 32'd0);
        report("bounce");

        // Long press: low for 30 samples
        start_scn();
        hold(1'b1, 5);
        k = edge_n + 1;
        hold(1'b0, 30);
        hold(1'b1, 10);
        check_eq("long_press_lat", 32'(last_press_edge - k), 32'(1 + DB_CYC));
        check_eq("long_lat",       32'(last_long_edge - k),  32'(1 + DB_CYC + LONG_CYC));
        check_eq("long_count",     32'(long_n), 32'd1);
        check_eq("long_rel_count", 32'(rel_n),  32'd1);
        report("long_press");

        // Release bounce inside a long press
        start_scn();
        hold(1'b1, 5);
        k = edge_n + 1;
        hold(1'b0, 8);
        hold(1'b1, 2);
        hold(1'b0, 20);
        check_eq("rbounce_no_rel", 32'(rel_n), 32'd0);
        check_eq("rbounce_pressed", 32'(pressed), 32'd1);
        hold(1'b1, 10);
        check_eq("rbounce_long_lat", 32'(last_long_edge - k), 32'(1 + DB_CYC + LONG_CYC));
        check_eq("rbounce_longs", 32'(long_n), 32'd1);
        report("release_bounce");

        // Release accepted on the same edge a long pulse would fire
        start_scn();
        hold(1'b1, 5);
        k = edge_n + 1;
        hold(1'b0, 10);
        hold(1'b1, 10);
        check_eq("tie_rel_lat", 32'(last_rel_edge - k), 32'(1 + DB_CYC + LONG_CYC));
        check_eq("tie_no_long", 32'(long_n), 32'd0);
        report("release_wins");

        // Wrap: 257 presses
        start_scn();
        for (int p = 0; p < 257; p++) begin
            hold(1'b0, 7);
            hold(1'b1, 7);
        end
        check_eq("wrap_count",    32'(press_count), 32'd1);
        check_eq("wrap_ledg",     32'(ledg), 32'h01);
        check_eq("wrap_presses",  32'(press_n), 32'd257);
        check_eq("wrap_releases", 32'(rel_n), 32'd257);
        report("wrap");

        // Reset while HELD, key kept low
        start_scn();
        hold(1'b1, 3);
        hold(1'b0, 8);
        check_eq("rmid_held", 32'(pressed), 32'd1);
        tick(1'b0, 1'b1);
        r = edge_n;
        check_eq("rmid_pressed_zero", 32'(pressed), 32'd0);
        check_eq("rmid_count_zero",   32'(press_count), 32'd0);
        hold(1'b0, 12);
        check_eq("rmid_press_lat", 32'(last_press_edge - (r + 1)), 32'(1 + DB_CYC));
        check_eq("rmid_count",     32'(press_count), 32'd1);
        hold(1'b1, 10);
        report("reset_mid_press");

        // Randomized segments, checked every cycle against the model
        start_scn();
        lvl = 1'b1;
        for (int s = 0; s < 150; s++) begin
            int len;
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(8, 24));
            else len = int'($urandom_range(1, 6));
            if ($urandom_range(0, 29) == 0) tick(lvl, 1'b1);
            else hold(lvl, len);
            lvl = !lvl;
        end
        hold(1'b1, 20);
        report("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
